// File: rtl/muldiv_sched.sv
// muldiv_sched: sequencer and arbiter for the shared multiply/divide unit.
//
// Serves two issue slots (slot 1 older, slot 0 younger). When both slots
// present a mul/div op in the same cycle they are serialised, older first.
// The execute stage is stalled while an operation is in flight. A one-cycle
// done pulse accompanies the HI/LO result for writeback.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   req_valid  per-slot request (index 1 = older slot)
//   req_op     per-slot op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   req_a      per-slot rs operand
//   req_b      per-slot rt operand
//   flush      pipeline flush; aborts any operation in flight
//   stall      hold the execute stage; requester keeps req_* stable while high
//   busy_slot  slot currently being served (meaningful outside IDLE)
//   done       one-cycle result-valid pulse
//   done_slot  slot whose result is on res_hi/res_lo
//   res_hi     HI result (remainder / product[63:32])
//   res_lo     LO result (quotient / product[31:0])
//
// State | meaning
// ------+-----------------------------------------------------------------
// IDLE  | pick the oldest unserved request, latch operands
// MUL   | product in flight, MUL_CYCLES cycles
// DIV   | 32 restoring-divide iterations plus one sign fix-up cycle
// DONE  | present result with done pulse, mark slot served

module muldiv_sched #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_ITERS  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [1:0][1:0]  req_op,
  input  logic [1:0][31:0] req_a,
  input  logic [1:0][31:0] req_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy_slot,
  output logic             done,
  output logic             done_slot,
  output logic [31:0]      res_hi,
  output logic [31:0]      res_lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS);

  state_t      state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic [1:0]  srv, srv_n;

  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;       // raw rt for multiply, divisor magnitude for divide
  logic        neg_q;     // quotient must be negated in fix-up
  logic        neg_r;     // remainder must be negated in fix-up
  logic [31:0] hi_w;      // product high / partial remainder
  logic [31:0] lo_w;      // product low / dividend shifting into quotient
  logic [31:0] res_hi_q;
  logic [31:0] res_lo_q;
  logic        slot_q;

  logic [1:0]  pend;
  logic        sel;
  logic [1:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        sel_signed_div;
  logic        other_pend;

  logic        stall_c;
  logic        done_c;
  logic        accept;
  logic        mul_last;
  logic        div_step;
  logic        div_fix;

  logic [63:0] ma;
  logic [63:0] mb;
  logic [63:0] prod;
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] rem_diff;

  // Request selection: older slot wins.
  always_comb begin
    pend           = req_valid & ~srv;
    sel            = pend[1];
    sel_op         = req_op[sel];
    sel_a          = req_a[sel];
    sel_b          = req_b[sel];
    sel_signed_div = sel_op[1] & ~sel_op[0];
    other_pend     = busy_slot ? pend[0] : pend[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 6'd0;
      srv   <= 2'b00;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      srv   <= srv_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    srv_n    = srv;
    stall_c  = 1'b0;
    done_c   = 1'b0;
    accept   = 1'b0;
    mul_last = 1'b0;
    div_step = 1'b0;
    div_fix  = 1'b0;

    case (state)
      S_IDLE: begin
        stall_c = |pend;
        if (|pend) begin
          accept  = 1'b1;
          cnt_n   = 6'd0;
          state_n = sel_op[1] ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        stall_c = 1'b1;
        if (cnt == MUL_LAST) begin
          mul_last = 1'b1;
          state_n  = S_DONE;
        end else begin
          cnt_n = cnt + 6'd1;
        end
      end
      S_DIV: begin
        stall_c = 1'b1;
        if (cnt == DIV_LAST) begin
          div_fix = 1'b1;
          state_n = S_DONE;
        end else begin
          div_step = 1'b1;
          cnt_n    = cnt + 6'd1;
        end
      end
      S_DONE: begin
        done_c           = 1'b1;
        stall_c          = other_pend;
        srv_n[busy_slot] = 1'b1;
        state_n          = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // The stage advances whenever stall is low, so the held requests go away.
    if (!stall_c) srv_n = 2'b00;

    if (reset || flush) begin
      state_n  = S_IDLE;
      srv_n    = 2'b00;
      stall_c  = 1'b0;
      done_c   = 1'b0;
      accept   = 1'b0;
      mul_last = 1'b0;
      div_step = 1'b0;
      div_fix  = 1'b0;
    end
  end

  // 64-bit product of sign- or zero-extended operands; low 64 bits are exact
  // for both MULT and MULTU.
  always_comb begin
    ma   = {{32{~op_q[0] & a_q[31]}}, a_q};
    mb   = {{32{~op_q[0] & b_q[31]}}, b_q};
    prod = ma * mb;
  end

  // One restoring-divide step: shift the next dividend bit into the remainder
  // and subtract the divisor if it fits.
  always_comb begin
    rem_sh   = {hi_w, lo_w[31]};
    rem_ge   = rem_sh >= {1'b0, b_q};
    rem_diff = rem_sh[31:0] - b_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_slot <= 1'b0;
      op_q      <= 2'b00;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      hi_w      <= 32'd0;
      lo_w      <= 32'd0;
      res_hi_q  <= 32'd0;
      res_lo_q  <= 32'd0;
      slot_q    <= 1'b0;
    end else begin
      if (accept) begin
        busy_slot <= sel;
        op_q      <= sel_op;
        a_q       <= sel_a;
        neg_q     <= sel_signed_div & (sel_a[31] ^ sel_b[31]);
        neg_r     <= sel_signed_div & sel_a[31];
        hi_w      <= 32'd0;
        if (sel_op[1]) begin
          lo_w <= (sel_signed_div && sel_a[31]) ? -sel_a : sel_a;
          b_q  <= (sel_signed_div && sel_b[31]) ? -sel_b : sel_b;
        end else begin
          lo_w <= 32'd0;
          b_q  <= sel_b;
        end
      end
      if (mul_last) begin
        hi_w <= prod[63:32];
        lo_w <= prod[31:0];
      end
      if (div_step) begin
        hi_w <= rem_ge ? rem_diff : rem_sh[31:0];
        lo_w <= {lo_w[30:0], rem_ge};
      end
      if (div_fix) begin
        hi_w <= neg_r ? -hi_w : hi_w;
        lo_w <= neg_q ? -lo_w : lo_w;
      end
      if (done_c) begin
        res_hi_q <= hi_w;
        res_lo_q <= lo_w;
        slot_q   <= busy_slot;
      end
    end
  end

  // In DONE the fresh result is forwarded so it lines up with the done pulse;
  // a flush in DONE drops done_c and the outputs fall back to the old result.
  always_comb begin
    stall     = stall_c;
    done      = done_c;
    done_slot = done_c ? busy_slot : slot_q;
    res_hi    = done_c ? hi_w : res_hi_q;
    res_lo    = done_c ? lo_w : res_lo_q;
  end

endmodule

// File: tb/tb_muldiv_sched.sv
module tb_muldiv_sched;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0][1:0]  req_op;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic             flush;
  logic             stall;
  logic             busy_slot;
  logic             done;
  logic             done_slot;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef struct {
    logic        slot;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  muldiv_sched #(.MUL_CYCLES(2), .DIV_ITERS(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .flush     (flush),
    .stall     (stall),
    .busy_slot (busy_slot),
    .done      (done),
    .done_slot (done_slot),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push(input logic slot, input logic [31:0] hi, input logic [31:0] lo, input int c);
    exp_t e;
    e.slot = slot; e.hi = hi; e.lo = lo; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done_slot), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_slot", 32'(done_slot), 32'(e.slot));
        chk("res_hi", res_hi, e.hi);
        chk("res_lo", res_lo, e.lo);
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic start(input logic [1:0] v, input logic [1:0] op1, input logic [1:0] op0,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input logic [31:0] a0, input logic [31:0] b0, output int t);
    @(posedge clk); #1;
    req_valid = v;
    req_op[1] = op1; req_op[0] = op0;
    req_a[1]  = a1;  req_b[1]  = b1;
    req_a[0]  = a0;  req_b[0]  = b0;
    t = cyc;
  endtask

  // Hold the request while stall is high; count the stalled cycles.
  task automatic release_req(input string name, input int exp_stall);
    int n = 0;
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (stall) n++;
      else begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
    chk({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    @(posedge clk); #1;
    req_valid = 2'b00;
  endtask

  initial begin
    int t;
    reset = 1'b1; flush = 1'b0; req_valid = 2'b00;
    req_op = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res_hi", res_hi, 32'd0);
    chk("rst_res_lo", res_lo, 32'd0);

    // MULT -2 * 3
    start(2'b10, OP_MULT, OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, t);
    push(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, t + 3);
    release_req("mult", 3);

    // MULTU same operands
    start(2'b10, OP_MULTU, OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, t);
    push(1'b1, 32'h0000_0002, 32'hFFFF_FFFA, t + 3);
    release_req("multu", 3);

    // DIV -7 / 2, from slot 0
    start(2'b01, OP_MULT, OP_DIV, 32'd0, 32'd0, 32'hFFFF_FFF9, 32'd2, t);
    push(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, t + 34);
    release_req("div", 34);

    // Flush mid-divide, then a new MULTU 2x2
    start(2'b10, OP_DIVU, OP_MULT, 32'd1000, 32'd3, 32'd0, 32'd0, t);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", 32'(stall), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    chk("flush_res_hi", res_hi, 32'hFFFF_FFFF);
    chk("flush_res_lo", res_lo, 32'hFFFF_FFFD);
    @(posedge clk); #1;
    flush = 1'b0;
    req_op[1] = OP_MULTU; req_a[1] = 32'd2; req_b[1] = 32'd2;
    push(1'b1, 32'd0, 32'd4, cyc + 3);
    release_req("post_flush", 3);

    // DIVU 100 / 7
    start(2'b10, OP_DIVU, OP_MULT, 32'd100, 32'd7, 32'd0, 32'd0, t);
    push(1'b1, 32'd2, 32'd14, t + 34);
    release_req("divu", 34);

    // DIVU by zero
    start(2'b10, OP_DIVU, OP_MULT, 32'd5, 32'd0, 32'd0, 32'd0, t);
    push(1'b1, 32'd5, 32'hFFFF_FFFF, t + 34);
    release_req("divu0", 34);

    // DIV negative by zero
    start(2'b01, OP_MULT, OP_DIV, 32'd0, 32'd0, 32'hFFFF_FFFB, 32'd0, t);
    push(1'b0, 32'hFFFF_FFFB, 32'd1, t + 34);
    release_req("divneg0", 34);

    // DIV overflow
    start(2'b10, OP_DIV, OP_MULT, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, t);
    push(1'b1, 32'd0, 32'h8000_0000, t + 34);
    release_req("divovf", 34);

    // Dual request: slot 1 MULTU 6x7, slot 0 DIVU 9/4
    start(2'b11, OP_MULTU, OP_DIVU, 32'd6, 32'd7, 32'd9, 32'd4, t);
    push(1'b1, 32'd0, 32'd42, t + 3);
    push(1'b0, 32'd1, 32'd2, t + 38);
    release_req("dual", 38);

    // Reset asserted mid-MUL
    start(2'b10, OP_MULT, OP_MULT, 32'd3, 32'd5, 32'd0, 32'd0, t);
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_stall", 32'(stall), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_done_slot", 32'(done_slot), 32'd0);
    chk("mrst_busy_slot", 32'(busy_slot), 32'd0);
    chk("mrst_res_hi", res_hi, 32'd0);
    chk("mrst_res_lo", res_lo, 32'd0);

    repeat (10) @(posedge clk);
    chk("pending_results", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
